// File: rtl/eks_round_ctrl.sv
// Round sequencer for the bcrypt expensive key schedule: issues the initial
// salted expand, 2^cost key/salt expand pairs, then CTEXT_ROUNDS encryptions.
module eks_round_ctrl #(
    parameter int COST_W       = 5,
    parameter int MIN_COST     = 4,
    parameter int MAX_COST     = 31,
    parameter int CTEXT_ROUNDS = 64,
    localparam int ITER_W      = MAX_COST + 1,
    localparam int CT_W        = (CTEXT_ROUNDS > 1) ? $clog2(CTEXT_ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              start,
    input  logic              abort,
    input  logic [COST_W-1:0] cost,
    output logic              op_valid,
    output logic [1:0]        op_code,
    input  logic              op_ready,
    input  logic              op_done,
    output logic [ITER_W-1:0] iter,
    output logic [CT_W-1:0]   ct_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              aborted
);

    typedef enum logic [3:0] {
        IDLE, INIT_ISSUE, INIT_WAIT, KEY_ISSUE, KEY_WAIT,
        SALT_ISSUE, SALT_WAIT, CT_ISSUE, CT_WAIT, DONE
    } state_t;

    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
    localparam logic [CT_W-1:0]   CT_LAST  = CT_W'(CTEXT_ROUNDS - 1);

    state_t             state, state_nxt;
    logic [COST_W-1:0]  cost_q;
    logic [ITER_W-1:0]  iter_q, iter_nxt, iter_last;
    logic [CT_W-1:0]    ct_q, ct_nxt;
    logic               err_q, err_nxt;
    logic               aborted_q, aborted_nxt;
    logic               cost_ld;
    logic               cost_legal;

    function automatic logic cost_in_range(input logic [COST_W-1:0] c);
        return (int'(c) >= MIN_COST) && (int'(c) <= MAX_COST);
    endfunction

    assign cost_legal = cost_in_range(cost);
    // Last pair index is 2^cost-1, formed at full ITER_W so cost=MAX_COST does not wrap.
    assign iter_last  = (ITER_ONE << cost_q) - ITER_ONE;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            iter_q    <= '0;
            ct_q      <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            iter_q    <= iter_nxt;
            ct_q      <= ct_nxt;
            err_q     <= err_nxt;
            aborted_q <= aborted_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (cost_ld) cost_q <= cost;
    end

    always_comb begin
        state_nxt   = state;
        iter_nxt    = iter_q;
        ct_nxt      = ct_q;
        err_nxt     = 1'b0;
        aborted_nxt = 1'b0;
        cost_ld     = 1'b0;
        op_valid    = 1'b0;
        op_code     = 2'd0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (cost_legal) begin
                        state_nxt = INIT_ISSUE;
                        iter_nxt  = '0;
                        ct_nxt    = '0;
                        cost_ld   = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            INIT_ISSUE: begin
                op_valid = 1'b1;
                op_code  = 2'd0;
                if (op_ready) state_nxt = INIT_WAIT;
            end
            INIT_WAIT: if (op_done) state_nxt = KEY_ISSUE;
            KEY_ISSUE: begin
                op_valid = 1'b1;
                op_code  = 2'd1;
                if (op_ready) state_nxt = KEY_WAIT;
            end
            KEY_WAIT: if (op_done) state_nxt = SALT_ISSUE;
            SALT_ISSUE: begin
                op_valid = 1'b1;
                op_code  = 2'd2;
                if (op_ready) state_nxt = SALT_WAIT;
            end
            SALT_WAIT: begin
                if (op_done) begin
                    if (iter_q == iter_last) begin
                        state_nxt = CT_ISSUE;
                    end else begin
                        iter_nxt  = iter_q + ITER_ONE;
                        state_nxt = KEY_ISSUE;
                    end
                end
            end
            CT_ISSUE: begin
                op_valid = 1'b1;
                op_code  = 2'd3;
                if (op_ready) state_nxt = CT_WAIT;
            end
            CT_WAIT: begin
                if (op_done) begin
                    if (ct_q == CT_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        ct_nxt    = ct_q + CT_W'(1);
                        state_nxt = CT_ISSUE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Abort overrides any pending op_done; counters keep their values.
        if (abort && (state != IDLE) && (state != DONE)) begin
            state_nxt   = IDLE;
            iter_nxt    = iter_q;
            ct_nxt      = ct_q;
            aborted_nxt = 1'b1;
        end
    end

    assign iter    = iter_q;
    assign ct_idx  = ct_q;
    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
    assign err     = err_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_eks_round_ctrl.sv
// Bench for eks_round_ctrl: a core responder with random stalls driven
// against an expected op list derived from cost and CTEXT_ROUNDS.
module tb_eks_round_ctrl;

    localparam int COST_W = 5;
    localparam int MIN_COST = 4;
    localparam int MAX_COST = 31;
    localparam int CTR = 64;
    localparam int ITER_W = MAX_COST + 1;
    localparam int CT_W = 6;

    logic              clk;
    logic              rst_l;
    logic              start;
    logic              abort;
    logic [COST_W-1:0] cost;
    logic              op_valid;
    logic [1:0]        op_code;
    logic              op_ready;
    logic              op_done;
    logic [ITER_W-1:0] iter;
    logic [CT_W-1:0]   ct_idx;
    logic              busy;
    logic              done;
    logic              err;
    logic              aborted;

    int total = 0;
    int bad = 0;

    eks_round_ctrl #(
        .COST_W(COST_W), .MIN_COST(MIN_COST), .MAX_COST(MAX_COST), .CTEXT_ROUNDS(CTR)
    ) dut (
        .clk(clk), .rst_l(rst_l), .start(start), .abort(abort), .cost(cost),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
        .iter(iter), .ct_idx(ct_idx), .busy(busy), .done(done), .err(err),
        .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One run. rand_stall=1 draws a 0..2 cycle ready stall per issue, else uses dly.
    // abort_k / reset_k name the op index at which to abort (in its wait) or reset (at its issue).
    task automatic run_job(input logic [COST_W-1:0] c, input bit rand_stall, input int dly,
                           input int abort_k, input int reset_k);
        int n_pair;
        int n_ops;
        int exp_op[$];
        int exp_it[$];
        int exp_ct[$];
        int k;
        int wc;
        int stalls;
        int cur_d;
        int cyc;
        bit fin;
        n_pair = 1 << c;
        n_ops  = 1 + 2 * n_pair + CTR;
        exp_op.push_back(0); exp_it.push_back(0); exp_ct.push_back(0);
        for (int i = 0; i < n_pair; i++) begin
            exp_op.push_back(1); exp_it.push_back(i); exp_ct.push_back(0);
            exp_op.push_back(2); exp_it.push_back(i); exp_ct.push_back(0);
        end
        for (int j = 0; j < CTR; j++) begin
            exp_op.push_back(3); exp_it.push_back(n_pair - 1); exp_ct.push_back(j);
        end
        k = 0; wc = 0; stalls = 0; cyc = 1; fin = 1'b0;
        cur_d = rand_stall ? int'($urandom_range(0, 2)) : dly;
        cost = c; start = 1'b1; abort = 1'b0; op_ready = 1'b0; op_done = 1'b0;
        tick;
        start = 1'b0;
        cost = COST_W'($urandom);
        while (!fin && cyc < 6000) begin
            if (done) begin
                chk("done_cycle", cyc, 2 * n_ops + 1 + stalls);
                chk("op_count", k, n_ops);
                chk("final_iter", iter, n_pair - 1);
                chk("final_ct", ct_idx, CTR - 1);
                chk("busy_in_done", busy, 0);
                fin = 1'b1;
            end else if (op_valid) begin
                chk("busy_issue", busy, 1);
                chk("op_code", op_code, exp_op[k]);
                chk("iter_issue", iter, exp_it[k]);
                chk("ct_issue", ct_idx, exp_ct[k]);
                if (k == reset_k) begin
                    rst_l = 1'b0;
                    #2;
                    chk("rst_op_valid", op_valid, 0);
                    chk("rst_op_code", op_code, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_iter", iter, 0);
                    chk("rst_ct", ct_idx, 0);
                    chk("rst_pulses", {done, err, aborted}, 0);
                    op_done = 1'b1; op_ready = 1'b1;
                    #2;
                    rst_l = 1'b1;
                    tick; tick;
                    chk("stray_done_busy", busy, 0);
                    chk("stray_done_valid", op_valid, 0);
                    op_done = 1'b0; op_ready = 1'b0;
                    return;
                end
                op_done = 1'($urandom_range(0, 1));
                if (wc >= cur_d) begin
                    op_ready = 1'b1;
                    stalls += cur_d;
                    wc = 0;
                    k++;
                    cur_d = rand_stall ? int'($urandom_range(0, 2)) : dly;
                end else begin
                    op_ready = 1'b0;
                    wc++;
                end
            end else begin
                chk("busy_wait", busy, 1);
                op_ready = 1'b0;
                op_done = 1'b1;
                if (k - 1 == abort_k) begin
                    abort = 1'b1;
                    tick;
                    chk("abort_pulse", aborted, 1);
                    chk("abort_valid", op_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    abort = 1'b0; op_done = 1'b0;
                    tick;
                    chk("abort_pulse_end", aborted, 0);
                    chk("abort_no_done", done, 0);
                    return;
                end
            end
            tick;
            cyc++;
        end
        if (!fin) chk("run_timeout", 0, 1);
        op_ready = 1'b0; op_done = 1'b0;
        tick;
        chk("done_pulse_end", done, 0);
        chk("idle_busy", busy, 0);
        chk("iter_hold", iter, n_pair - 1);
        chk("ct_hold", ct_idx, CTR - 1);
    endtask

    task automatic bad_cost(input logic [COST_W-1:0] c);
        cost = c; start = 1'b1;
        tick;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_valid", op_valid, 0);
        tick;
        chk("err_pulse_end", err, 0);
        chk("err_valid2", op_valid, 0);
    endtask

    initial begin
        logic [COST_W-1:0] over;
        rst_l = 1'b0; start = 1'b0; abort = 1'b0; cost = '0;
        op_ready = 1'b0; op_done = 1'b0;
        tick;
        chk("reset_outputs", {op_valid, op_code, busy, done, err, aborted}, 0);
        chk("reset_iter", iter, 0);
        chk("reset_ct", ct_idx, 0);
        rst_l = 1'b1;
        tick;

        run_job(5'd4, 1'b0, 0, -1, -1);
        run_job(5'd4, 1'b0, 3, -1, -1);

        bad_cost(5'd3);
        over = COST_W'(MAX_COST + 1);
        bad_cost(over);

        run_job(5'd4, 1'b1, 0, 11, -1);
        run_job(5'd4, 1'b0, 0, -1, -1);

        run_job(5'd4, 1'b1, 0, -1, 40);

        start = 1'b1; abort = 1'b1; cost = 5'd4;
        tick;
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_pulses", {err, aborted, op_valid}, 0);
        tick;
        chk("sa_busy2", busy, 0);

        run_job(5'd5, 1'b1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eks_round_ctrl.md
# eks_round_ctrl

Parametrised round sequencer for the bcrypt expensive key schedule (EKS). On `start` it latches a cost, then drives the Blowfish core through one op-at-a-time handshake: the initial salted expand, 2^cost key/salt expand pairs, and CTEXT_ROUNDS ciphertext encryptions. It generalises the fixed-cost state/cycle-count sequencing to a configurable cost range and ciphertext length. It adds cost range checking, abort, and a ready/done handshake to the core. It sits between the host interface and the core datapath, replacing hard-wired enable chains.

## Interface
Parameters:
- COST_W, 5: width of `cost` input.
- MIN_COST, 4: smallest legal cost.
- MAX_COST, 31: largest legal cost; ITER_W = MAX_COST+1.
- CTEXT_ROUNDS, 64: number of final encryptions; CT_W = clog2(CTEXT_ROUNDS).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_l  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancel current run.
- cost  in  COST_W  log2 iteration count; latched when start is accepted.
- op_valid  out  1  op request to core.
- op_code  out  2  op type: 0 INIT_EXPAND (salt+key), 1 EXPAND_KEY, 2 EXPAND_SALT, 3 ENCRYPT_CT.
- op_ready  in  1  core accepts op (transfer = op_valid & op_ready).
- op_done  in  1  core finished the accepted op.
- iter  out  ITER_W  current expand-pair index.
- ct_idx  out  CT_W  current encryption index.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse: illegal cost rejected.
- aborted  out  1  one-cycle pulse: run cancelled.

## Operation
- States: IDLE, INIT_ISSUE, INIT_WAIT, KEY_ISSUE, KEY_WAIT, SALT_ISSUE, SALT_WAIT, CT_ISSUE, CT_WAIT, DONE.
- IDLE to INIT_ISSUE: start=1, abort=0, and MIN_COST ≤ cost ≤ MAX_COST. Latch cost; clear iter and ct_idx.
- Illegal cost at start: err=1 for the next cycle, remain IDLE, no op issued.
- *_ISSUE states: op_valid=1 with op_code fixed for the state. On transfer, go to the matching *_WAIT. op_valid and op_code stay stable until transfer.
- *_WAIT states: op_valid=0. op_done is acted on only in WAIT states; op_done seen in ISSUE or IDLE is ignored.
- INIT_WAIT + op_done → KEY_ISSUE.
- KEY_WAIT + op_done → SALT_ISSUE.
- SALT_WAIT + op_done:
  - if iter == 2^cost_latched − 1 → CT_ISSUE;
  - else iter+1 → KEY_ISSUE.
- CT_WAIT + op_done:
  - if ct_idx == CTEXT_ROUNDS−1 → DONE;
  - else ct_idx+1 → CT_ISSUE.
- DONE: done=1, busy=0, then IDLE next cycle. iter and ct_idx hold their final values until the next accepted start.
- iter compare is done at ITER_W bits, so 2^MAX_COST−1 is representable with no wrap.
- Abort in any non-IDLE state other than DONE: next state IDLE, op_valid drops, aborted=1 for one cycle, no done pulse. An in-flight op_done is ignored.
- Abort and start in the same IDLE cycle: abort wins; nothing starts and no pulse is produced.
- Abort in IDLE or DONE: ignored.
- A cost change during a run has no effect. Start held high after DONE begins a new run from IDLE.

## Timing
- Reset values: state IDLE; op_valid, op_code, iter, ct_idx, busy, done, err, aborted all 0.
- Reset mid-run takes effect immediately, with no done or aborted pulse.
- Start accepted at edge 0: busy=1, op_valid=1, op_code=0 from cycle 1.
- Per op, minimum 2 cycles (ISSUE, WAIT) when op_ready and op_done are tied high.
- Op count N = 1 + 2·2^cost + CTEXT_ROUNDS.
- Minimum schedule: busy cycles 1..2N, done in cycle 2N+1, back to IDLE in cycle 2N+2.
- A new start can be accepted at the edge ending cycle 2N+2.
- err and aborted are asserted in the cycle after the causing edge.

## Test plan
- cost=4, CTEXT_ROUNDS=64, op_ready/op_done tied 1 → op sequence 0, then (1,2)×16, then 3×64 (97 ops); done pulse in cycle 195; final iter=15, ct_idx=63.
- cost=4, op_ready low for 3 cycles on every ISSUE → op_code stable while op_valid is waiting; the op sequence is unchanged; done in cycle 195+3·97=486.
- cost=3 and cost=MAX_COST+1 → err pulse, busy stays 0, op_valid is never asserted.
- abort asserted in KEY_WAIT at iter=5 → aborted pulse next cycle, op_valid=0, no done; a following start with cost=4 completes normally.
- rst_l pulsed low in CT_ISSUE → all outputs 0 asynchronously; a stray op_done in IDLE has no effect.
- start and abort asserted together in IDLE → no run starts; busy, err, and aborted all stay 0.
